alu_sequencer: RTL and testbench

Multi-cycle sequencer between the CPU control unit and the combinational ALU. Accepts one operation per start/done handshake and latches operands. It drives the ALU opcode and operands, holding them stable for the multicycle MUL and DIV paths. Shifts and rotates are executed iteratively, one bit per cycle, inside the block. The result is captured into the Z register pair (z_hi/z_lo) for the bus.

---
 rtl/alu_sequencer_if.sv | 23 ++
 rtl/alu_sequencer.sv | 174 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// CPU-side bus of the ALU sequencer: request handshake, operands and result.
interface alu_sequencer_if;
    logic        start;
    logic [4:0]  op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [31:0] z_lo;
    logic [31:0] z_hi;
    logic        div_err;
    logic        illegal;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, z_lo, z_hi, div_err, illegal
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, z_lo, z_hi, div_err, illegal
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer between the CPU control unit and the combinational ALU.
//
// state  | meaning
// IDLE   | waiting for start
// EXEC   | ALU operands/opcode held, down-counter running to capture
// SHIFT  | iterative shift/rotate, one bit per cycle
// FAULT  | DIV by zero or unknown opcode, error result captured on exit
// FINISH | done pulse; start accepted here for back-to-back ops
module alu_sequencer #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic                  clock,
    input  logic                  clear,
    alu_sequencer_if.slave        bus,
    output logic [4:0]            alu_op,
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    input  logic [31:0]           alu_z_lo,
    input  logic [31:0]           alu_z_hi
);
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [2:0] {IDLE, EXEC, SHIFT, FAULT, FINISH} state_t;

    state_t      state, next_state;
    logic [4:0]  op_q;
    logic [31:0] work;
    logic [15:0] cnt;
    logic [15:0] cnt_load;
    logic        accept;
    logic        op_shift, op_mul, op_div, op_legal;

    // Classify the incoming opcode so the accept branch can pick a path.
    always_comb begin
        op_shift = 1'b0;
        op_mul   = 1'b0;
        op_div   = 1'b0;
        op_legal = 1'b1;
        case (bus.op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NEG, OP_NOT: ;
            OP_MUL:  op_mul = 1'b1;
            OP_DIV:  op_div = 1'b1;
            OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: op_shift = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    // State register; clear aborts any in-flight operation.
    always_ff @(posedge clock) begin
        if (clear) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state and handshake/ALU-select outputs.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        cnt_load   = 16'd1;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        alu_op     = 5'b00000;
        if (op_mul)        cnt_load = 16'(MUL_CYCLES);
        else if (op_div)   cnt_load = 16'(DIV_CYCLES);
        else if (op_shift) cnt_load = {11'd0, bus.b_in[4:0]};
        case (state)
            IDLE, FINISH: begin
                bus.done   = (state == FINISH);
                next_state = IDLE;
                if (bus.start) begin
                    accept = 1'b1;
                    if (!op_legal || (op_div && bus.b_in == 32'd0)) next_state = FAULT;
                    else if (op_shift)                               next_state = SHIFT;
                    else                                             next_state = EXEC;
                end
            end
            EXEC: begin
                bus.busy = 1'b1;
                alu_op   = op_q;
                if (cnt == 16'd1) next_state = FINISH;
            end
            SHIFT: begin
                bus.busy = 1'b1;
                if (cnt == 16'd0) next_state = FINISH;
            end
            FAULT: begin
                bus.busy   = 1'b1;
                next_state = FINISH;
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand latching, timing counter, shifter and result capture.
    always_ff @(posedge clock) begin
        if (clear) begin
            op_q        <= 5'd0;
            work        <= 32'd0;
            cnt         <= 16'd0;
            alu_a       <= 32'd0;
            alu_b       <= 32'd0;
            bus.z_lo    <= 32'd0;
            bus.z_hi    <= 32'd0;
            bus.div_err <= 1'b0;
            bus.illegal <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= bus.op;
                work <= bus.a_in;
                cnt  <= cnt_load;
                if (next_state == EXEC) begin
                    alu_a <= bus.a_in;
                    alu_b <= bus.b_in;
                end
            end
            case (state)
                EXEC: begin
                    cnt <= cnt - 16'd1;
                    if (cnt == 16'd1) begin
                        bus.z_lo    <= alu_z_lo;
                        bus.z_hi    <= (op_q == OP_MUL || op_q == OP_DIV) ? alu_z_hi : 32'd0;
                        bus.div_err <= 1'b0;
                        bus.illegal <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                        case (op_q)
                            OP_SHR:  work <= {1'b0, work[31:1]};
                            OP_SHRA: work <= {work[31], work[31:1]};
                            OP_SHL:  work <= {work[30:0], 1'b0};
                            OP_ROR:  work <= {work[0], work[31:1]};
                            OP_ROL:  work <= {work[30:0], work[31]};
                            default: work <= work;
                        endcase
                    end else begin
                        bus.z_lo    <= work;
                        bus.z_hi    <= 32'd0;
                        bus.div_err <= 1'b0;
                        bus.illegal <= 1'b0;
                    end
                end
                FAULT: begin
                    // work still holds operand A here, which is the DIV-by-0 remainder.
                    if (op_q == OP_DIV) begin
                        bus.z_lo    <= 32'hFFFF_FFFF;
                        bus.z_hi    <= work;
                        bus.div_err <= 1'b1;
                        bus.illegal <= 1'b0;
                    end else begin
                        bus.z_lo    <= 32'd0;
                        bus.z_hi    <= 32'd0;
                        bus.div_err <= 1'b0;
                        bus.illegal <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed test of alu_sequencer against a behavioural ALU.
module tb_alu_sequencer;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;

    logic        clock = 1'b0;
    logic        clear;
    logic [4:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_z_lo, alu_z_hi;
    logic [63:0] prod;
    int          checks = 0;
    int          errors = 0;

    alu_sequencer_if bus ();

    alu_sequencer #(.MUL_CYCLES(4), .DIV_CYCLES(8)) dut (
        .clock    (clock),
        .clear    (clear),
        .bus      (bus),
        .alu_op   (alu_op),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_z_lo (alu_z_lo),
        .alu_z_hi (alu_z_hi)
    );

    always #5 clock = ~clock;

    // Behavioural ALU; z_hi is junk except for MUL/DIV so the DUT must zero it.
    always_comb begin
        prod     = 64'(alu_a) * 64'(alu_b);
        alu_z_lo = 32'd0;
        alu_z_hi = 32'hDEAD_BEEF;
        case (alu_op)
            5'b00011: alu_z_lo = alu_a + alu_b;
            5'b00100: alu_z_lo = alu_a - alu_b;
            5'b01010: alu_z_lo = alu_a & alu_b;
            5'b01011: alu_z_lo = alu_a | alu_b;
            5'b10001: alu_z_lo = -alu_a;
            5'b10010: alu_z_lo = ~alu_a;
            5'b01111: begin
                alu_z_lo = prod[31:0];
                alu_z_hi = prod[63:32];
            end
            5'b10000: begin
                alu_z_lo = (alu_b != 0) ? alu_a / alu_b : 32'd0;
                alu_z_hi = (alu_b != 0) ? alu_a % alu_b : 32'd0;
            end
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one op and wait for done; lat counts edges from accept to done sample (ADD = 2).
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output bit timeout);
        int n;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a_in  = a;
        bus.b_in  = b;
        tick();
        bus.start = 1'b0;
        n = 0;
        timeout = 1'b1;
        while (n < 100) begin
            tick();
            n++;
            if (bus.done) begin
                timeout = 1'b0;
                break;
            end
        end
        lat = n + 1;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        tick();
        tick();
        clear = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.div_err, bus.illegal} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {bus.busy, bus.done, bus.div_err, bus.illegal});
        end
        checks++;
        if ({bus.z_lo, bus.z_hi} !== 64'd0) begin
            errors++;
            $display("FAIL reset_z: got %h expected 0", {bus.z_lo, bus.z_hi});
        end
        checks++;
        if ({alu_op, alu_a, alu_b} !== 69'd0) begin
            errors++;
            $display("FAIL reset_alu: got op=%b a=%h b=%h expected 0", alu_op, alu_a, alu_b);
        end
    endtask

    task automatic test_add_sub();
        int lat;
        bit to;
        run_op(OP_ADD, 32'd5, 32'd7, lat, to);
        checks++;
        if (to || lat != 2 || bus.z_lo !== 32'd12 || bus.z_hi !== 32'd0) begin
            errors++;
            $display("FAIL add: got lat=%0d lo=%h hi=%h expected lat=2 lo=0000000c hi=0", lat, bus.z_lo, bus.z_hi);
        end
        run_op(OP_SUB, 32'd3, 32'd5, lat, to);
        checks++;
        if (to || lat != 2 || bus.z_lo !== 32'hFFFF_FFFE || bus.z_hi !== 32'd0) begin
            errors++;
            $display("FAIL sub: got lat=%0d lo=%h hi=%h expected lat=2 lo=fffffffe hi=0", lat, bus.z_lo, bus.z_hi);
        end
    endtask

    task automatic test_mul();
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.a_in  = 32'h0001_0000;
        bus.b_in  = 32'h0001_0000;
        tick();
        bus.start = 1'b0;
        bus.a_in  = 32'h1111_1111;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (alu_op !== OP_MUL || alu_a !== 32'h0001_0000 || alu_b !== 32'h0001_0000
                || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL mul_hold[%0d]: got op=%b a=%h b=%h busy=%b done=%b expected op=01111 a=b=00010000 busy=1 done=0",
                         i, alu_op, alu_a, alu_b, bus.busy, bus.done);
            end
            tick();
        end
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || alu_op !== 5'd0
            || bus.z_hi !== 32'd1 || bus.z_lo !== 32'd0) begin
            errors++;
            $display("FAIL mul_result: got done=%b busy=%b op=%b hi=%h lo=%h expected done=1 busy=0 op=0 hi=1 lo=0",
                     bus.done, bus.busy, alu_op, bus.z_hi, bus.z_lo);
        end
        tick();
    endtask

    task automatic test_div();
        int lat;
        bit to;
        run_op(OP_DIV, 32'd100, 32'd7, lat, to);
        checks++;
        if (to || lat != 9 || bus.z_lo !== 32'd14 || bus.z_hi !== 32'd2 || bus.div_err !== 1'b0) begin
            errors++;
            $display("FAIL div: got lat=%0d lo=%0d hi=%0d err=%b expected lat=9 lo=14 hi=2 err=0", lat, bus.z_lo, bus.z_hi, bus.div_err);
        end
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a_in  = 32'd9;
        bus.b_in  = 32'd0;
        tick();
        bus.start = 1'b0;
        checks++;
        if (alu_op !== 5'd0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL div0_busy: got op=%b busy=%b done=%b expected op=0 busy=1 done=0", alu_op, bus.busy, bus.done);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || alu_op !== 5'd0 || bus.z_lo !== 32'hFFFF_FFFF
            || bus.z_hi !== 32'd9 || bus.div_err !== 1'b1 || bus.illegal !== 1'b0) begin
            errors++;
            $display("FAIL div0: got done=%b op=%b lo=%h hi=%h err=%b ill=%b expected done=1 op=0 lo=ffffffff hi=9 err=1 ill=0",
                     bus.done, alu_op, bus.z_lo, bus.z_hi, bus.div_err, bus.illegal);
        end
        tick();
        run_op(OP_ADD, 32'd1, 32'd1, lat, to);
        checks++;
        if (to || bus.div_err !== 1'b0 || bus.z_lo !== 32'd2) begin
            errors++;
            $display("FAIL div_err_clear: got err=%b lo=%h expected err=0 lo=2", bus.div_err, bus.z_lo);
        end
    endtask

    task automatic test_shift();
        logic [4:0]  ops  [6] = '{OP_SHRA, OP_ROL, OP_SHL, OP_SHR, OP_ROR, OP_SHL};
        logic [31:0] as   [6] = '{32'h8000_0000, 32'h8000_0001, 32'h0000_1234, 32'h0000_00F0, 32'h0000_0001, 32'h0000_0001};
        logic [31:0] bs   [6] = '{32'd4, 32'd1, 32'hFFFF_FFE0, 32'd4, 32'd1, 32'd31};
        logic [31:0] exps [6] = '{32'hF800_0000, 32'h0000_0003, 32'h0000_1234, 32'h0000_000F, 32'h8000_0000, 32'h8000_0000};
        int          lats [6] = '{6, 3, 2, 6, 3, 33};
        int lat;
        bit to;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], lat, to);
            checks++;
            if (to || lat != lats[i] || bus.z_lo !== exps[i] || bus.z_hi !== 32'd0) begin
                errors++;
                $display("FAIL shift[%0d]: got lat=%0d lo=%h hi=%h expected lat=%0d lo=%h hi=0",
                         i, lat, bus.z_lo, bus.z_hi, lats[i], exps[i]);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int lat;
        bit to;
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.a_in  = 32'd6;
        bus.b_in  = 32'd7;
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1;
        bus.op    = OP_ADD;
        bus.a_in  = 32'd100;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.z_lo !== 32'd42 || bus.z_hi !== 32'd0) begin
            errors++;
            $display("FAIL ignore_busy: got done=%b lo=%0d hi=%0d expected done=1 lo=42 hi=0", bus.done, bus.z_lo, bus.z_hi);
        end
        lat = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.done || bus.busy) lat++;
        end
        checks++;
        if (lat != 0) begin
            errors++;
            $display("FAIL ignore_busy_idle: got %0d active cycles expected 0", lat);
        end
        to = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat;
        bit to;
        run_op(OP_ADD, 32'd1, 32'd2, lat, to);
        bus.start = 1'b1;
        bus.op    = OP_ADD;
        bus.a_in  = 32'd10;
        bus.b_in  = 32'd20;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.z_lo !== 32'd3) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b done=%b lo=%0d expected busy=1 done=0 lo=3", bus.busy, bus.done, bus.z_lo);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.z_lo !== 32'd30) begin
            errors++;
            $display("FAIL b2b_result: got done=%b lo=%0d expected done=1 lo=30", bus.done, bus.z_lo);
        end
        tick();
    endtask

    task automatic test_illegal();
        int lat;
        bit to;
        run_op(5'b11111, 32'd55, 32'd66, lat, to);
        checks++;
        if (to || lat != 2 || bus.illegal !== 1'b1 || bus.div_err !== 1'b0
            || bus.z_lo !== 32'd0 || bus.z_hi !== 32'd0) begin
            errors++;
            $display("FAIL illegal: got lat=%0d ill=%b err=%b lo=%h hi=%h expected lat=2 ill=1 err=0 lo=0 hi=0",
                     lat, bus.illegal, bus.div_err, bus.z_lo, bus.z_hi);
        end
        run_op(OP_SUB, 32'd9, 32'd4, lat, to);
        checks++;
        if (to || bus.illegal !== 1'b0 || bus.z_lo !== 32'd5) begin
            errors++;
            $display("FAIL illegal_clear: got ill=%b lo=%0d expected ill=0 lo=5", bus.illegal, bus.z_lo);
        end
    endtask

    task automatic test_clear();
        int lat;
        int active;
        bit to;
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.a_in  = 32'd3;
        bus.b_in  = 32'd3;
        tick();
        bus.start = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.div_err, bus.illegal} !== 4'b0 || {bus.z_lo, bus.z_hi} !== 64'd0
            || alu_op !== 5'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
            errors++;
            $display("FAIL clear_state: got busy=%b done=%b lo=%h hi=%h op=%b a=%h b=%h expected all 0",
                     bus.busy, bus.done, bus.z_lo, bus.z_hi, alu_op, alu_a, alu_b);
        end
        active = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done || bus.busy) active++;
        end
        checks++;
        if (active != 0) begin
            errors++;
            $display("FAIL clear_no_done: got %0d active cycles expected 0", active);
        end
        run_op(OP_ADD, 32'd2, 32'd2, lat, to);
        checks++;
        if (to || lat != 2 || bus.z_lo !== 32'd4) begin
            errors++;
            $display("FAIL clear_recover: got lat=%0d lo=%0d expected lat=2 lo=4", lat, bus.z_lo);
        end
    endtask

    initial begin
        clear     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 5'd0;
        bus.a_in  = 32'd0;
        bus.b_in  = 32'd0;
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_shift();
        test_ignore_busy();
        test_back_to_back();
        test_illegal();
        test_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
